pmul_ctrl: RTL

Sequencer between the local-bus interface and the pointwise modular-multiplier datapath. It latches the key operand `b` on `blk_krdy`. On `blk_drdy` it streams NCOEF coefficients of `a` from the interface FIFO into the pipelined multiplier, collects the results in issue order, packs them into `blk_dout` and pulses `blk_dvld`. It also drives the scope trigger that frames the active multiply window for side-channel capture.

---
 rtl/pmul_pkg.sv | 16 +
 rtl/pmul_res_buf.sv | 54 +++++
 rtl/pmul_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pmul_pkg.sv
// Shared types and constants for the pointwise modular-multiplier sequencer.
package pmul_pkg;

  localparam int          CW        = 24;
  localparam int          NCOEF_MAX = 5;
  localparam int          DOUT_W    = 128;
  localparam logic [22:0] Q         = 23'd8380417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pmul_res_buf.sv
// Result slots captured in issue order, cleared per operation, packed into the
// 128-bit output word when the final result lands.
module pmul_res_buf #(
  parameter int NCOEF = 5,
  parameter int CW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [2:0]    wr_idx,
  input  logic [CW-1:0] wr_data,
  input  logic          load,
  output logic [127:0]  dout
);
  import pmul_pkg::*;

  logic [CW-1:0] res_q [NCOEF_MAX];
  logic [CW-1:0] res_d [NCOEF_MAX];
  logic [127:0]  dout_q, dout_d;

  always_comb begin
    res_d  = res_q;
    dout_d = dout_q;
    if (clr) begin
      for (int i = 0; i < NCOEF_MAX; i++) res_d[i] = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NCOEF_MAX; i++) begin
        if (i < NCOEF && wr_idx == 3'(i)) res_d[i] = wr_data;
      end
    end
    // Pack from the next-state slots so the final result is included in the
    // same edge that enters DONE; unused slots and the top byte stay zero.
    if (load) begin
      dout_d = '0;
      for (int i = 0; i < NCOEF_MAX; i++) begin
        if (i < NCOEF) dout_d[i*CW +: CW] = res_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF_MAX; i++) res_q[i] <= '0;
      dout_q <= '0;
    end else begin
      res_q  <= res_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pmul_ctrl.sv
// Sequencer between the local-bus interface and the pipelined modular multiplier:
// latches b, streams NCOEF coefficients of a, collects results and frames the SCA trigger.
module pmul_ctrl #(
  parameter int NCOEF   = 5,
  parameter int MUL_LAT = 4,
  parameter int CW      = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blk_en,
  input  logic          blk_krdy,
  input  logic          blk_drdy,
  input  logic [CW-1:0] b_in,
  input  logic [CW-1:0] a_in,
  output logic          a_pop,
  output logic [CW-1:0] mul_a,
  output logic [CW-1:0] mul_b,
  output logic          mul_vld_in,
  input  logic [CW-1:0] mul_res,
  input  logic          mul_vld_out,
  output logic [127:0]  blk_dout,
  output logic          blk_kvld,
  output logic          blk_dvld,
  output logic          busy,
  output logic          trigger
);
  import pmul_pkg::*;

  // state | meaning
  // IDLE  | waiting for krdy (load b) or drdy (start)
  // ISSUE | popping a and feeding the multiplier, one coefficient per cycle
  // DRAIN | all operands issued, waiting for the remaining results
  // DONE  | output word valid, blk_dvld pulse

  if (NCOEF < 1 || NCOEF > NCOEF_MAX || MUL_LAT < 0 || NCOEF * CW > 128) begin : g_param_chk
    $error("pmul_ctrl: unsupported NCOEF/MUL_LAT/CW combination");
  end

  localparam logic [2:0] LAST_IDX = 3'(NCOEF - 1);
  localparam logic [2:0] NC3      = 3'(NCOEF);

  state_t        state_q, state_d;
  logic [2:0]    iss_cnt_q, iss_cnt_d;
  logic [2:0]    res_cnt_q, res_cnt_d;
  logic [CW-1:0] b_reg_q, b_reg_d;
  logic          kvld_q, kvld_d;
  logic          res_clr, res_wr, dout_load;
  logic          issue_ok;

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    res_cnt_d = res_cnt_q;
    b_reg_d   = b_reg_q;
    kvld_d    = 1'b0;
    res_clr   = 1'b0;
    res_wr    = 1'b0;
    dout_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        // krdy has priority; a coincident drdy is dropped.
        if (blk_krdy) begin
          b_reg_d = b_in;
          kvld_d  = 1'b1;
        end else if (blk_drdy && blk_en) begin
          iss_cnt_d = '0;
          res_cnt_d = '0;
          res_clr   = 1'b1;
          state_d   = ISSUE;
        end
      end

      ISSUE, DRAIN: begin
        if (!blk_en) begin
          iss_cnt_d = '0;
          res_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          if (state_q == ISSUE) begin
            iss_cnt_d = iss_cnt_q + 3'd1;
            if (iss_cnt_q == LAST_IDX) state_d = DRAIN;
          end
          // Completion depends only on the result count, so a zero-latency
          // multiplier can finish straight out of ISSUE.
          if (mul_vld_out && res_cnt_q < NC3) begin
            res_wr    = 1'b1;
            res_cnt_d = res_cnt_q + 3'd1;
            if (res_cnt_q == LAST_IDX) begin
              dout_load = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end

      DONE: begin
        iss_cnt_d = '0;
        res_cnt_d = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      iss_cnt_q <= '0;
      res_cnt_q <= '0;
      b_reg_q   <= '0;
      kvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      res_cnt_q <= res_cnt_d;
      b_reg_q   <= b_reg_d;
      kvld_q    <= kvld_d;
    end
  end

  // Gating by blk_en stops operand traffic in the very cycle an abort starts.
  assign issue_ok   = (state_q == ISSUE) && blk_en;
  assign a_pop      = issue_ok;
  assign mul_vld_in = issue_ok;
  assign mul_a      = a_in;
  assign mul_b      = b_reg_q;
  assign busy       = (state_q != IDLE);
  assign trigger    = (state_q == ISSUE) || (state_q == DRAIN);
  assign blk_dvld   = (state_q == DONE);
  assign blk_kvld   = kvld_q;

  pmul_res_buf #(
    .NCOEF(NCOEF),
    .CW   (CW)
  ) u_res_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (res_clr),
    .wr_en  (res_wr),
    .wr_idx (res_cnt_q),
    .wr_data(mul_res),
    .load   (dout_load),
    .dout   (blk_dout)
  );

endmodule
